// File: rtl/apb_node_pkg.sv
// rtl/apb_node_pkg.sv - shared types and default address map for the APB node
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_node_state_e;

  localparam logic [31:0] APB_NODE_ERR_DATA = 32'hBADA_BADA;
  localparam int          APB_NODE_NB_PORTS = 26;
  localparam int          GPIO_IDX          = 0;
  localparam int          UART1_IDX         = 15;

  // Default SoC peripheral map, 4 KiB windows except DEBUG and CRYPTO.
  function automatic logic [31:0] map_start(input int i);
    case (i)
      0:  map_start = 32'h1A10_1000; // GPIO
      1:  map_start = 32'h1A10_2000; // UART0
      2:  map_start = 32'h1A10_3000; // SPIM0
      3:  map_start = 32'h1A10_4000; // TIMER
      4:  map_start = 32'h1A10_5000; // EVENT
      5:  map_start = 32'h1A10_6000; // I2C0
      6:  map_start = 32'h1A10_7000; // FLL
      7:  map_start = 32'h1A10_8000; // SOC_CTRL
      8:  map_start = 32'h1A10_9000; // WDT
      9:  map_start = 32'h1A10_A000; // RTC
      10: map_start = 32'h1A10_B000; // ADC
      11: map_start = 32'h1A10_C000; // SPIM1
      12: map_start = 32'h1A10_D000; // I2C1
      13: map_start = 32'h1A10_E000; // I2S
      14: map_start = 32'h1A11_0000; // DEBUG
      15: map_start = 32'h1A12_1000; // UART1
      16: map_start = 32'h1A12_2000; // UART2
      17: map_start = 32'h1A12_3000; // SPIM2
      18: map_start = 32'h1A12_4000; // CAN
      19: map_start = 32'h1A12_5000; // PWM
      20: map_start = 32'h1A12_6000; // CAM
      21: map_start = 32'h1A12_7000; // SDIO
      22: map_start = 32'h1A12_8000; // HYPER
      23: map_start = 32'h1A12_9000; // QSPI
      24: map_start = 32'h1B00_0000; // CRYPTO
      25: map_start = 32'h1B00_5000; // IOM
      default: map_start = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] map_end(input int i);
    case (i)
      14:      map_end = 32'h1A11_FFFF;
      24:      map_end = 32'h1B00_4FFF;
      default: map_end = (i >= 0 && i < APB_NODE_NB_PORTS) ? map_start(i) + 32'h0000_0FFF
                                                           : 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - priority address decoder, lowest matching rule wins
module apb_addr_decode #(
  parameter int NB_PORTS = 26,
  parameter int AW       = 32,
  parameter int IDX_W    = 5
) (
  input  logic [AW-1:0]          addr,
  input  logic [NB_PORTS*AW-1:0] start_addr,
  input  logic [NB_PORTS*AW-1:0] end_addr,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  // Scan downward so the last assignment comes from the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NB_PORTS - 1; i >= 0; i--) begin
      if (addr >= start_addr[i*AW +: AW] && addr <= end_addr[i*AW +: AW]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_tmo.sv
// rtl/apb_node_tmo.sv - APB 1-to-N node with registered phases, unmapped error and slave timeout
module apb_node_tmo
  import apb_node_pkg::*;
#(
  parameter int                        NB_PORTS       = 26,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        TIMEOUT        = 1024,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_DATA       = APB_NODE_ERR_DATA
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0]          s_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]          s_pwdata_i,
  input  logic                               s_pwrite_i,
  input  logic                               s_psel_i,
  input  logic                               s_penable_i,
  output logic [APB_DATA_WIDTH-1:0]          s_prdata_o,
  output logic                               s_pready_o,
  output logic                               s_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]          m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]          m_pwdata_o,
  output logic                               m_pwrite_o,
  output logic [NB_PORTS-1:0]                m_psel_o,
  output logic [NB_PORTS-1:0]                m_penable_o,
  input  logic [NB_PORTS*APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_PORTS-1:0]                m_pready_i,
  input  logic [NB_PORTS-1:0]                m_pslverr_i,
  input  logic [NB_PORTS*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_PORTS*APB_ADDR_WIDTH-1:0] end_addr_i,
  output logic                               tmo_evt_o,
  output logic                               unmapped_evt_o
);

  localparam int               IDX_W      = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int               CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CNT_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  apb_node_state_e               state_q, state_d;
  logic [IDX_W-1:0]              idx_q;
  logic [IDX_W-1:0]              dec_idx;
  logic                          dec_hit;
  logic [CNT_W-1:0]              cnt_q;
  logic                          accept;
  logic                          sel_pready;
  logic                          sel_pslverr;
  logic [APB_DATA_WIDTH-1:0]     sel_prdata;
  logic                          tmo_hit;

  apb_addr_decode #(
    .NB_PORTS (NB_PORTS),
    .AW       (APB_ADDR_WIDTH),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr       (s_paddr_i),
    .start_addr (start_addr_i),
    .end_addr   (end_addr_i),
    .hit        (dec_hit),
    .idx        (dec_idx)
  );

  assign accept      = s_psel_i && !s_penable_i;
  assign sel_pready  = m_pready_i[idx_q];
  assign sel_pslverr = m_pslverr_i[idx_q];
  assign sel_prdata  = m_prdata_i[int'(idx_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  assign tmo_hit     = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dec_hit ? SETUP : DONE;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_pready || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Downstream strobes derive only from flops, never from upstream inputs.
  always_comb begin
    m_psel_o    = '0;
    m_penable_o = '0;
    for (int i = 0; i < NB_PORTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        m_psel_o[i]    = (state_q == SETUP) || (state_q == ACCESS);
        m_penable_o[i] = (state_q == ACCESS);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      m_paddr_o      <= '0;
      m_pwdata_o     <= '0;
      m_pwrite_o     <= 1'b0;
      s_prdata_o     <= '0;
      s_pslverr_o    <= 1'b0;
      s_pready_o     <= 1'b0;
      tmo_evt_o      <= 1'b0;
      unmapped_evt_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_pready_o     <= (state_d == DONE);
      tmo_evt_o      <= 1'b0;
      unmapped_evt_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec_hit) begin
              m_paddr_o  <= s_paddr_i;
              m_pwdata_o <= s_pwdata_i;
              m_pwrite_o <= s_pwrite_i;
              idx_q      <= dec_idx;
            end else begin
              s_pslverr_o    <= 1'b1;
              s_prdata_o     <= '0;
              unmapped_evt_o <= 1'b1;
            end
          end
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          // A ready slave wins over a timeout firing in the same cycle.
          if (sel_pready) begin
            s_prdata_o  <= sel_prdata;
            s_pslverr_o <= sel_pslverr;
          end else if (tmo_hit) begin
            s_prdata_o  <= ERR_DATA;
            s_pslverr_o <= 1'b1;
            tmo_evt_o   <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
